board_reset_seq: RTL and testbench

Parametrised board-level reset sequencer for FPGA top-level wrappers. It gathers N debounced active-low reset buttons and the clock-generator lock indicator into one reset request, then releases N_OUT active-high reset domains in a fixed order, one every STAGE_CYCLES clocks. It records the cause of the last reset. It sits between the board pins/MMCM and the SoC core, AON and peripheral resets, and replaces the ad-hoc AND-of-buttons plus vendor reset IP.

---
 rtl/board_reset_pkg.sv | 23 ++
 rtl/board_reset_debounce.sv | 36 +++
 rtl/board_reset_seq.sv | 170 +++++++++++++++++
 tb/tb_board_reset_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_reset_pkg.sv
// Shared types and sizing helper for the board reset sequencer.
// Optional watchdog is controlled by RESET_SEQ_WDT_EN in board_reset_seq.
package board_reset_pkg;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_BTN  = 2'd1,
    CAUSE_LOCK = 2'd2,
    CAUSE_WDT  = 2'd3
  } rst_cause_e;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_e;

  // Bits needed for a counter that must hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/board_reset_debounce.sv
// One button: 2-FF synchroniser into a saturating low-time counter.
// o_pressed asserts after DEB_CYCLES low samples and drops on the first high sample.
module board_reset_debounce
  import board_reset_pkg::*;
#(
  parameter int DEB_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_n,
  output logic o_pressed
);

  localparam int CW = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn_n};
      if (r_sync[1]) begin
        r_cnt <= '0;
      end else if (r_cnt != DEB_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_pressed = (r_cnt == DEB_MAX);

endmodule

// File: rtl/board_reset_seq.sv
// Board reset sequencer: merges buttons and PLL lock, releases rst_out[0..N_OUT-1] in order.
// Define RESET_SEQ_WDT_EN to add the wdt_kick port and a RUN-state watchdog.
module board_reset_seq
  import board_reset_pkg::*;
#(
  parameter int N_BTN        = 2,
  parameter int N_OUT        = 3,
  parameter int DEB_CYCLES   = 50000,
  parameter int STAGE_CYCLES = 16
`ifdef RESET_SEQ_WDT_EN
  , parameter int WDT_CYCLES = 1 << 24
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  input  logic             pll_locked,
`ifdef RESET_SEQ_WDT_EN
  input  logic             wdt_kick,
`endif
  output logic [N_OUT-1:0] rst_out,
  output logic             seq_done,
  output logic [1:0]       rst_cause
);

  localparam int SW = cnt_w(STAGE_CYCLES - 1);
  localparam int IW = cnt_w(N_OUT - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_OUT - 1);

  logic [N_BTN-1:0] w_pressed;
  logic [1:0]       r_lock_sync;
  logic             w_lock_req;
  logic             w_btn_req;
  logic             w_wdt_req;
  logic             w_req;

  seq_state_e       r_state;
  seq_state_e       w_state_nxt;
  logic [SW-1:0]    r_cnt;
  logic [SW-1:0]    w_cnt_nxt;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_idx_nxt;
  logic [N_OUT-1:0] r_rst_out;
  logic [N_OUT-1:0] w_rst_nxt;
  rst_cause_e       r_cause;
  rst_cause_e       w_cause_nxt;
  rst_cause_e       w_cause_sel;
  logic             w_stage_end;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    board_reset_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_btn_n  (btn_n[g]),
      .o_pressed(w_pressed[g])
    );
  end

  // Lock synchroniser starts "unlocked" so reset always holds the outputs first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock_sync <= 2'b00;
    end else begin
      r_lock_sync <= {r_lock_sync[0], pll_locked};
    end
  end

`ifdef RESET_SEQ_WDT_EN
  localparam int WW = cnt_w(WDT_CYCLES - 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

  logic [WW-1:0] r_wdt_cnt;

  always_ff @(posedge clk) begin
    if (reset || (r_state != ST_RUN) || wdt_kick) begin
      r_wdt_cnt <= '0;
    end else if (r_wdt_cnt != WDT_LAST) begin
      r_wdt_cnt <= r_wdt_cnt + WW'(1);
    end
  end

  assign w_wdt_req = (r_state == ST_RUN) && (r_wdt_cnt == WDT_LAST);
`else
  assign w_wdt_req = 1'b0;
`endif

  assign w_lock_req  = ~r_lock_sync[1];
  assign w_btn_req   = |w_pressed;
  assign w_req       = w_lock_req | w_btn_req | w_wdt_req;
  assign w_stage_end = (r_cnt == STAGE_LAST);
  assign w_cause_sel = w_lock_req ? CAUSE_LOCK : (w_btn_req ? CAUSE_BTN : CAUSE_WDT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ASSERT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ASSERT:  if (!w_req && w_stage_end) w_state_nxt = ST_RELEASE;
      ST_RELEASE: begin
        if (w_req) begin
          w_state_nxt = ST_ASSERT;
        end else if (w_stage_end && (r_idx == IDX_LAST)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN:     if (w_req) w_state_nxt = ST_ASSERT;
      default:    w_state_nxt = ST_ASSERT;
    endcase
  end

  always_comb begin
    w_cnt_nxt   = '0;
    w_idx_nxt   = r_idx;
    w_rst_nxt   = r_rst_out;
    w_cause_nxt = r_cause;
    seq_done    = (r_state == ST_RUN);
    case (r_state)
      ST_ASSERT: begin
        w_rst_nxt = '1;
        w_idx_nxt = '0;
        if (!w_req && !w_stage_end) w_cnt_nxt = r_cnt + SW'(1);
      end
      ST_RELEASE: begin
        if (w_stage_end) begin
          for (int k = 0; k < N_OUT; k++) begin
            if (r_idx == IW'(k)) w_rst_nxt[k] = 1'b0;
          end
          w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
        end else begin
          w_cnt_nxt = r_cnt + SW'(1);
        end
      end
      default: ;
    endcase
    // A request outside ASSERT overrides any release in progress this cycle.
    if ((r_state != ST_ASSERT) && w_req) begin
      w_rst_nxt   = '1;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
      w_cause_nxt = w_cause_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rst_out <= '1;
      r_cause   <= CAUSE_POR;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_rst_out <= w_rst_nxt;
      r_cause   <= w_cause_nxt;
    end
  end

  assign rst_out   = r_rst_out;
  assign rst_cause = r_cause;

endmodule

// File: tb/tb_board_reset_seq.sv
// Bench for board_reset_seq (N_BTN=2, N_OUT=3, DEB_CYCLES=8, STAGE_CYCLES=4, WDT_CYCLES=20).
// Expected output snapshots are queued with their due cycle and compared at the falling edge.
module tb_board_reset_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn_n;
  logic       pll_locked;
  logic [2:0] rst_out;
  logic       seq_done;
  logic [1:0] rst_cause;
`ifdef RESET_SEQ_WDT_EN
  logic       wdt_kick;
  logic       autokick;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         due;
    logic [2:0] rst;
    logic       done;
    logic [1:0] cause;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_tot  = 0;

`ifdef RESET_SEQ_WDT_EN
  board_reset_seq #(
    .N_BTN(2), .N_OUT(3), .DEB_CYCLES(8), .STAGE_CYCLES(4), .WDT_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .pll_locked(pll_locked),
    .wdt_kick(wdt_kick),
    .rst_out(rst_out), .seq_done(seq_done), .rst_cause(rst_cause)
  );
`else
  board_reset_seq #(
    .N_BTN(2), .N_OUT(3), .DEB_CYCLES(8), .STAGE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .pll_locked(pll_locked),
    .rst_out(rst_out), .seq_done(seq_done), .rst_cause(rst_cause)
  );
`endif

  function automatic void push(int due, logic [2:0] r, logic d, logic [1:0] ca);
    exp_t e;
    e.due = due; e.rst = r; e.done = d; e.cause = ca;
    sbq.push_back(e);
  endfunction

  // Power-on reset, then the full release sequence timed from sync release.
  task automatic test_reset();
    exp_t e;
    int   c0;
    int   base;
    reset = 1'b1; btn_n = 2'b11; pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    n_tot++;
    if (rst_out !== 3'b111 || seq_done !== 1'b0 || rst_cause !== 2'd0)
      $display("FAIL reset_values: got rst_out=%b seq_done=%b cause=%0d, want 111 0 0",
               rst_out, seq_done, rst_cause);
    else n_pass++;
    c0 = cyc + 1;
    base = c0 + 2;
    push(c0 + 1,    3'b111, 1'b0, 2'd0);
    push(base + 7,  3'b111, 1'b0, 2'd0);
    push(base + 8,  3'b110, 1'b0, 2'd0);
    push(base + 11, 3'b110, 1'b0, 2'd0);
    push(base + 12, 3'b100, 1'b0, 2'd0);
    push(base + 15, 3'b100, 1'b0, 2'd0);
    push(base + 16, 3'b000, 1'b1, 2'd0);
    for (int t = 0; t <= 22; t++) begin
      @(negedge clk);
      while (sbq.size() != 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front(); n_tot++;
        if (e.due != cyc || rst_out !== e.rst || seq_done !== e.done || rst_cause !== e.cause)
          $display("FAIL por_seq @%0d: got rst_out=%b seq_done=%b cause=%0d, want %b %b %0d (due @%0d)",
                   cyc, rst_out, seq_done, rst_cause, e.rst, e.done, e.cause, e.due);
        else n_pass++;
      end
      if (cyc == c0) reset = 1'b0;
    end
    n_tot++;
    if (sbq.size() != 0) begin
      $display("FAIL por_seq_left: got %0d unchecked, want 0", sbq.size());
      sbq.delete();
    end else n_pass++;
  endtask

  // 7-cycle glitch ignored; 12-cycle press asserts at 2+8+1 and restarts the sequence.
  task automatic test_glitch();
    exp_t e;
    int   c0;
    int   c1;
    int   base;
    c0 = cyc + 1;
    c1 = c0 + 25;
    base = c1 + 15;
    push(c0 + 5,    3'b000, 1'b1, 2'd0);
    push(c0 + 12,   3'b000, 1'b1, 2'd0);
    push(c0 + 20,   3'b000, 1'b1, 2'd0);
    push(c1 + 10,   3'b000, 1'b1, 2'd0);
    push(c1 + 11,   3'b111, 1'b0, 2'd1);
    push(c1 + 14,   3'b111, 1'b0, 2'd1);
    push(base + 7,  3'b111, 1'b0, 2'd1);
    push(base + 8,  3'b110, 1'b0, 2'd1);
    push(base + 12, 3'b100, 1'b0, 2'd1);
    push(base + 16, 3'b000, 1'b1, 2'd1);
    for (int t = 0; t <= 60; t++) begin
      @(negedge clk);
      while (sbq.size() != 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front(); n_tot++;
        if (e.due != cyc || rst_out !== e.rst || seq_done !== e.done || rst_cause !== e.cause)
          $display("FAIL glitch @%0d: got rst_out=%b seq_done=%b cause=%0d, want %b %b %0d (due @%0d)",
                   cyc, rst_out, seq_done, rst_cause, e.rst, e.done, e.cause, e.due);
        else n_pass++;
      end
      if (cyc == c0)      btn_n[1] = 1'b0;
      if (cyc == c0 + 7)  btn_n[1] = 1'b1;
      if (cyc == c1)      btn_n[1] = 1'b0;
      if (cyc == c1 + 12) btn_n[1] = 1'b1;
    end
    n_tot++;
    if (sbq.size() != 0) begin
      $display("FAIL glitch_left: got %0d unchecked, want 0", sbq.size());
      sbq.delete();
    end else n_pass++;
  endtask

  // Debounced press and lock loss become visible in the same cycle: LOCK wins.
  task automatic test_simultaneous();
    exp_t e;
    int   c0;
    c0 = cyc + 1;
    push(c0 + 10, 3'b000, 1'b1, 2'd1);
    push(c0 + 11, 3'b111, 1'b0, 2'd2);
    push(c0 + 30, 3'b100, 1'b0, 2'd2);
    push(c0 + 31, 3'b000, 1'b1, 2'd2);
    for (int t = 0; t <= 36; t++) begin
      @(negedge clk);
      while (sbq.size() != 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front(); n_tot++;
        if (e.due != cyc || rst_out !== e.rst || seq_done !== e.done || rst_cause !== e.cause)
          $display("FAIL simultaneous @%0d: got rst_out=%b seq_done=%b cause=%0d, want %b %b %0d (due @%0d)",
                   cyc, rst_out, seq_done, rst_cause, e.rst, e.done, e.cause, e.due);
        else n_pass++;
      end
      if (cyc == c0)      btn_n[0] = 1'b0;
      if (cyc == c0 + 8)  pll_locked = 1'b0;
      if (cyc == c0 + 12) begin btn_n[0] = 1'b1; pll_locked = 1'b1; end
    end
    n_tot++;
    if (sbq.size() != 0) begin
      $display("FAIL simultaneous_left: got %0d unchecked, want 0", sbq.size());
      sbq.delete();
    end else n_pass++;
  endtask

  // Re-reset (cause back to POR), lose lock after bit 0 released, relock and re-sequence.
  task automatic test_lock_loss();
    exp_t e;
    int   c0;
    int   base;
    int   base2;
    c0 = cyc + 1;
    base  = c0 + 4;
    base2 = base + 16;
    push(c0 + 2,     3'b111, 1'b0, 2'd0);
    push(base + 8,   3'b110, 1'b0, 2'd0);
    push(base + 11,  3'b110, 1'b0, 2'd0);
    push(base + 12,  3'b111, 1'b0, 2'd2);
    push(base2 + 7,  3'b111, 1'b0, 2'd2);
    push(base2 + 8,  3'b110, 1'b0, 2'd2);
    push(base2 + 12, 3'b100, 1'b0, 2'd2);
    push(base2 + 16, 3'b000, 1'b1, 2'd2);
    for (int t = 0; t <= 38; t++) begin
      @(negedge clk);
      while (sbq.size() != 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front(); n_tot++;
        if (e.due != cyc || rst_out !== e.rst || seq_done !== e.done || rst_cause !== e.cause)
          $display("FAIL lock_loss @%0d: got rst_out=%b seq_done=%b cause=%0d, want %b %b %0d (due @%0d)",
                   cyc, rst_out, seq_done, rst_cause, e.rst, e.done, e.cause, e.due);
        else n_pass++;
      end
      if (cyc == c0)        reset = 1'b1;
      if (cyc == c0 + 2)    reset = 1'b0;
      if (cyc == base + 9)  pll_locked = 1'b0;
      if (cyc == base + 14) pll_locked = 1'b1;
    end
    n_tot++;
    if (sbq.size() != 0) begin
      $display("FAIL lock_loss_left: got %0d unchecked, want 0", sbq.size());
      sbq.delete();
    end else n_pass++;
  endtask

`ifdef RESET_SEQ_WDT_EN
  // Kicks every 10 cycles hold RUN; the 20th edge after the last kick asserts with cause WDT.
  task automatic test_wdt();
    exp_t e;
    int   c0;
    int   k;
    autokick = 1'b0;
    c0 = cyc + 1;
    k  = c0 + 30;
    push(c0 + 5,  3'b000, 1'b1, 2'd2);
    push(c0 + 25, 3'b000, 1'b1, 2'd2);
    push(k + 10,  3'b000, 1'b1, 2'd2);
    push(k + 20,  3'b000, 1'b1, 2'd2);
    push(k + 21,  3'b111, 1'b0, 2'd3);
    push(k + 36,  3'b100, 1'b0, 2'd3);
    push(k + 37,  3'b000, 1'b1, 2'd3);
    for (int t = 0; t <= 70; t++) begin
      @(negedge clk);
      while (sbq.size() != 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front(); n_tot++;
        if (e.due != cyc || rst_out !== e.rst || seq_done !== e.done || rst_cause !== e.cause)
          $display("FAIL wdt @%0d: got rst_out=%b seq_done=%b cause=%0d, want %b %b %0d (due @%0d)",
                   cyc, rst_out, seq_done, rst_cause, e.rst, e.done, e.cause, e.due);
        else n_pass++;
      end
      wdt_kick = ((cyc - c0) % 10 == 0) && (cyc <= k);
    end
    wdt_kick = 1'b0;
    autokick = 1'b1;
    n_tot++;
    if (sbq.size() != 0) begin
      $display("FAIL wdt_left: got %0d unchecked, want 0", sbq.size());
      sbq.delete();
    end else n_pass++;
  endtask
`else
  // Without the watchdog, RUN holds indefinitely with no kicks.
  task automatic test_no_wdt();
    exp_t e;
    int   c0;
    c0 = cyc + 1;
    push(c0 + 30, 3'b000, 1'b1, 2'd2);
    push(c0 + 59, 3'b000, 1'b1, 2'd2);
    for (int t = 0; t <= 60; t++) begin
      @(negedge clk);
      while (sbq.size() != 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front(); n_tot++;
        if (e.due != cyc || rst_out !== e.rst || seq_done !== e.done || rst_cause !== e.cause)
          $display("FAIL no_wdt @%0d: got rst_out=%b seq_done=%b cause=%0d, want %b %b %0d (due @%0d)",
                   cyc, rst_out, seq_done, rst_cause, e.rst, e.done, e.cause, e.due);
        else n_pass++;
      end
    end
    n_tot++;
    if (sbq.size() != 0) begin
      $display("FAIL no_wdt_left: got %0d unchecked, want 0", sbq.size());
      sbq.delete();
    end else n_pass++;
  endtask
`endif

  initial begin
`ifdef RESET_SEQ_WDT_EN
    wdt_kick = 1'b0;
    autokick = 1'b1;
    fork
      forever begin
        @(negedge clk);
        if (autokick) wdt_kick = (cyc % 8 == 0);
      end
    join_none
`endif
    test_reset();
    test_glitch();
    test_simultaneous();
    test_lock_loss();
`ifdef RESET_SEQ_WDT_EN
    test_wdt();
`else
    test_no_wdt();
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
